// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one endpoint pair, streams one framebuffer address per step.
// Optional clipping against the framebuffer bounds is enabled by defining LINE_RASTER_CLIP_EN.
module line_rasterizer #(
  parameter int COORD_W = 10,
  parameter int FB_W    = 640,
  parameter int FB_H    = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] color_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] color_out,
  output logic               busy,
  output logic               done
);

  localparam int FBW_BITS = $clog2(FB_W + 1);
  localparam int PROD_W   = COORD_W + FBW_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  state_t                    r_state;
  logic [COORD_W-1:0]        r_cx0, r_cy0, r_cx1, r_cy1;
  logic [COLOR_W-1:0]        r_col;
  logic [COORD_W-1:0]        r_x, r_y, r_x1;
  logic signed [COORD_W:0]   r_dx, r_dy, r_err;
  logic                      r_steep, r_yneg;
  logic                      r_in_ready, r_busy, r_done, r_out_valid;
  logic [ADDR_W-1:0]         r_fb_addr;
  logic [COLOR_W-1:0]        r_color_out;

  logic [COORD_W-1:0]        w_adx, w_ady;
  logic                      w_steep, w_swap, w_yneg;
  logic [COORD_W-1:0]        w_ax0, w_ay0, w_ax1, w_ay1;
  logic [COORD_W-1:0]        w_sx0, w_sy0, w_sx1, w_sy1;
  logic [COORD_W-1:0]        w_sdx, w_sdy;
  logic signed [COORD_W:0]   w_err_sub, w_err_nx;
  logic [COORD_W-1:0]        w_x_nx, w_y_nx;
  logic                      w_last, w_step, w_vis_first, w_vis_next;

  // a is the stepping axis, b the minor axis; steep lines map them back to (px,py) = (b,a)
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b,
                                                 input logic               steep);
    logic [PROD_W-1:0] px, py, prod;
    px   = steep ? PROD_W'(b) : PROD_W'(a);
    py   = steep ? PROD_W'(a) : PROD_W'(b);
    prod = py * PROD_W'(FB_W) + px;
    return ADDR_W'(prod);
  endfunction

  always_comb begin
    w_adx   = (r_cx1 >= r_cx0) ? r_cx1 - r_cx0 : r_cx0 - r_cx1;
    w_ady   = (r_cy1 >= r_cy0) ? r_cy1 - r_cy0 : r_cy0 - r_cy1;
    w_steep = w_ady > w_adx;
    w_ax0   = w_steep ? r_cy0 : r_cx0;
    w_ay0   = w_steep ? r_cx0 : r_cy0;
    w_ax1   = w_steep ? r_cy1 : r_cx1;
    w_ay1   = w_steep ? r_cx1 : r_cy1;
    w_swap  = w_ax0 > w_ax1;
    w_sx0   = w_swap ? w_ax1 : w_ax0;
    w_sy0   = w_swap ? w_ay1 : w_ay0;
    w_sx1   = w_swap ? w_ax0 : w_ax1;
    w_sy1   = w_swap ? w_ay0 : w_ay1;
    w_sdx   = w_sx1 - w_sx0;
    w_sdy   = (w_sy1 >= w_sy0) ? w_sy1 - w_sy0 : w_sy0 - w_sy1;
    w_yneg  = !(w_sy0 < w_sy1);
  end

  always_comb begin
    w_err_sub = r_err - r_dy;
    w_x_nx    = r_x + COORD_W'(1);
    w_last    = (r_x == r_x1);
    if (w_err_sub[COORD_W]) begin
      w_y_nx   = r_yneg ? r_y - COORD_W'(1) : r_y + COORD_W'(1);
      w_err_nx = w_err_sub + r_dx;
    end else begin
      w_y_nx   = r_y;
      w_err_nx = w_err_sub;
    end
  end

`ifdef LINE_RASTER_CLIP_EN
  function automatic logic pix_vis(input logic [COORD_W-1:0] a,
                                   input logic [COORD_W-1:0] b,
                                   input logic               steep);
    logic [31:0] px, py;
    px = steep ? 32'(b) : 32'(a);
    py = steep ? 32'(a) : 32'(b);
    return (px < 32'(FB_W)) && (py < 32'(FB_H));
  endfunction

  assign w_vis_first = pix_vis(w_sx0, w_sy0, w_steep);
  assign w_vis_next  = pix_vis(w_x_nx, w_y_nx, r_steep);
  // hidden pixels are not offered downstream, so they step without waiting for out_ready
  assign w_step      = (r_state == S_DRAW) && (!r_out_valid || out_ready);
`else
  assign w_vis_first = 1'b1;
  assign w_vis_next  = 1'b1;
  assign w_step      = (r_state == S_DRAW) && r_out_valid && out_ready;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cx0       <= '0;
      r_cy0       <= '0;
      r_cx1       <= '0;
      r_cy1       <= '0;
      r_col       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_x1        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_steep     <= 1'b0;
      r_yneg      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_fb_addr   <= '0;
      r_color_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cx0      <= x0;
            r_cy0      <= y0;
            r_cx1      <= x1;
            r_cy1      <= y1;
            r_col      <= color_in;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_x         <= w_sx0;
          r_y         <= w_sy0;
          r_x1        <= w_sx1;
          r_dx        <= {1'b0, w_sdx};
          r_dy        <= {1'b0, w_sdy};
          r_err       <= {1'b0, w_sdx >> 1};
          r_steep     <= w_steep;
          r_yneg      <= w_yneg;
          r_fb_addr   <= pix_addr(w_sx0, w_sy0, w_steep);
          r_color_out <= r_col;
          r_out_valid <= w_vis_first;
          r_state     <= S_DRAW;
        end
        S_DRAW: begin
          if (w_step) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_x         <= w_x_nx;
              r_y         <= w_y_nx;
              r_err       <= w_err_nx;
              r_fb_addr   <= pix_addr(w_x_nx, w_y_nx, r_steep);
              r_out_valid <= w_vis_next;
            end
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign fb_addr   = r_fb_addr;
  assign color_out = r_color_out;

endmodule

// File: doc/line_rasterizer.md
LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have parameter COORD_W, default 10, meaning the unsigned endpoint coordinate width.
REQ-002 SHALL have parameter FB_W, default 640, meaning the framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 480, meaning the framebuffer height in pixels.
REQ-004 SHALL have parameter ADDR_W, default 19, meaning the framebuffer address width.
REQ-005 SHALL have parameter COLOR_W, default 6, meaning the colour width.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge; one clock domain.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  line command valid.
- in_ready  out  1  block can accept a command.
- x0, y0, x1, y1  in  COORD_W  endpoint coordinates.
- color_in  in  COLOR_W  line colour.
- out_valid  out  1  pixel valid.
- out_ready  in  1  framebuffer writer accepts the pixel.
- fb_addr  out  ADDR_W  pixel address.
- color_out  out  COLOR_W  pixel colour.
- busy  out  1  command in progress.
- done  out  1  one-cycle end-of-line pulse.

Function
REQ-007 SHALL implement an FSM with states IDLE, SETUP, DRAW, DONE.
REQ-008 SHALL drive in_ready high only in IDLE.
REQ-009 SHALL latch x0, y0, x1, y1 and color_in when in_valid and in_ready are both high, then move to SETUP.
REQ-010 SHALL set busy high in SETUP, DRAW and DONE.
REQ-011 In SETUP, SHALL set steep = |y1-y0| > |x1-x0|; a tie is not steep.
REQ-012 When steep, SHALL swap x and y of both endpoints.
REQ-013 After REQ-012, SHALL swap the endpoints if x0 > x1, so stepping is always in ascending x.
REQ-014 SHALL compute dx = x1-x0 and dy = |y1-y0|, set ystep = +1 if y0 < y1 and -1 otherwise, and set err = dx>>1.
REQ-015 SHALL hold differences and err as signed COORD_W+1 bit values; no overflow is permitted for any COORD_W-bit input.
REQ-016 SHALL enter DRAW one cycle after SETUP; the first out_valid occurs two cycles after the accept cycle.
REQ-017 In DRAW, SHALL present the current pixel with fb_addr = py*FB_W + px, where (px,py) = (y,x) if steep and (x,y) otherwise.
REQ-018 In DRAW, SHALL drive color_out with the latched colour.
REQ-019 SHALL advance one step per cycle in which out_valid and out_ready are both high: x += 1; err -= dy; if err < 0 then y += ystep and err += dx.
REQ-020 SHALL emit exactly dx+1 pixels per line; a degenerate line (equal endpoints) SHALL emit one pixel.
REQ-021 While out_valid is high and out_ready is low, SHALL hold fb_addr, color_out and all internal state stable.
REQ-022 After accepting the pixel where x == x1, SHALL go to DONE.
REQ-023 SHALL pulse done for exactly one cycle in DONE and return to IDLE on the next cycle.
REQ-024 SHALL sustain a throughput of one pixel per cycle while out_ready is held high.
REQ-025 SHALL compute fb_addr at full product width and truncate it to ADDR_W.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE and, asynchronously, set out_valid=0, busy=0, done=0, fb_addr=0 and color_out=0, including mid-line; in_ready SHALL read 1 once IDLE is forced.
REQ-027 A line interrupted by reset SHALL NOT resume; no further pixels of that line SHALL appear after reset deassertion.

Configuration
REQ-028 With macro LINE_RASTER_CLIP_EN defined, pixels with px >= FB_W or py >= FB_H SHALL be suppressed: out_valid stays low, the step advances unconditionally that cycle, and done still pulses after the final x.
REQ-029 With LINE_RASTER_CLIP_EN undefined, every pixel SHALL be emitted with its address per REQ-025, and no clipping logic SHALL be present.

Verification (FB_W=640)
REQ-030 Horizontal line: (3,0)->(0,0), out_ready=1 -> fb_addr sequence 0, 1, 2, 3 on consecutive cycles starting two cycles after accept; done one cycle after the last pixel.
REQ-031 Steep line: (5,5)->(5,8) -> fb_addr sequence 3205, 3845, 4485, 5125.
REQ-032 Negative-slope diagonal: (0,2)->(2,0) -> fb_addr sequence 1280, 641, 2; tie case not steep.
REQ-033 Backpressure: (0,0)->(2,2) with out_ready low for 3 cycles on the second pixel -> 641 held stable for those cycles, then 1282; exactly 3 pixels total.
REQ-034 Clipping: (638,0)->(641,0) -> with LINE_RASTER_CLIP_EN, addresses 638 and 639 only and done after 4 step cycles; without the macro, 638, 639, 640, 641.
REQ-035 Reset mid-line: rst_n low during DRAW of (0,0)->(9,0) -> out_valid=0 and busy=0 in the same cycle; no further pixels; a new command is accepted afterward and runs correctly.
